grid_move_engine: RTL

- Game-state writer for the 4x4 2048 board; it owns the cell grid that the VGA block renderer reads.
- Accepts one move request at a time over a valid/ready handshake and slides/merges all four lines, one line per cycle.
- Spawns a new tile at a pseudo-random empty cell after any move that changed the board.
- Publishes the flat grid, score, win and lose flags to the display and LED logic.

---
 rtl/game_pkg.sv | 31 +++
 rtl/grid_move_engine_if.sv | 27 ++
 rtl/line_merge.sv | 51 +++++
 rtl/grid_move_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, types and small helpers for the 2048 move engine.
// Cells hold the tile exponent; 0 means empty.
package game_pkg;

  localparam int CELL_W  = 4;
  localparam int SCORE_W = 24;
  localparam int WIN_EXP = 11;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [3:0] line_t;
  typedef enum logic [1:0] {IDLE, MERGE, SPAWN, DONE} state_t;

  function automatic logic [3:0] idx(input logic [1:0] x, input logic [1:0] y);
    return {y, x};
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic cell_t new_tile(input logic [15:0] v);
    return (v[7:4] == 4'd0) ? CELL_W'(2) : CELL_W'(1);
  endfunction

endpackage

// File: rtl/grid_move_engine_if.sv
// Move request handshake plus the published board state.
interface grid_move_engine_if;
  import game_pkg::*;

  logic                   iMove_valid;
  logic [1:0]             iMove_dir;
  logic                   oMove_ready;
  logic                   iNew_game;
  logic [16*CELL_W-1:0]   oGrid;
  logic [SCORE_W-1:0]     oScore;
  logic                   oBusy;
  logic                   oDone;
  logic                   oChanged;
  logic                   oWin;
  logic                   oLose;

  modport master (
    output iMove_valid, iMove_dir, iNew_game,
    input  oMove_ready, oGrid, oScore, oBusy, oDone, oChanged, oWin, oLose
  );

  modport slave (
    input  iMove_valid, iMove_dir, iNew_game,
    output oMove_ready, oGrid, oScore, oBusy, oDone, oChanged, oWin, oLose
  );

endinterface

// File: rtl/line_merge.sv
// Slides one line of four cells toward its front and merges equal neighbours once.
// Cells arrive and leave front-first; the top module handles orientation.
module line_merge
  import game_pkg::*;
(
  input  line_t       line_in,
  output line_t       line_out,
  output logic        changed,
  output logic [16:0] score_delta
);

  cell_t      comp [5];
  cell_t      res  [5];
  logic [2:0] n;
  logic [2:0] j;
  logic       skip;

  always_comb begin
    comp        = '{default: '0};
    res         = '{default: '0};
    n           = '0;
    j           = '0;
    skip        = 1'b0;
    score_delta = '0;
    line_out    = '0;
    for (int i = 0; i < 4; i++) begin
      if (line_in[i] != '0) begin
        comp[n] = line_in[i];
        n       = n + 3'd1;
      end
    end
    // comp[4] stays empty so the last cell never finds a partner
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1] && comp[i] != {CELL_W{1'b1}}) begin
          res[j]      = comp[i] + 1'b1;
          score_delta = score_delta + (17'd1 << (comp[i] + 1'b1));
          skip        = 1'b1;
        end else begin
          res[j] = comp[i];
        end
        j = j + 3'd1;
      end
    end
    for (int i = 0; i < 4; i++) line_out[i] = res[i];
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/grid_move_engine.sv
// 2048 board owner: merges one line per cycle, spawns tiles from a free-running
// LFSR and publishes grid, score and win/lose flags.
module grid_move_engine
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic iCLK,
  input logic iRST,
  grid_move_engine_if.slave bus
);

  state_t                   state;
  logic [15:0]              lfsr;
  logic [15:0][CELL_W-1:0]  grid;
  logic [15:0][CELL_W-1:0]  grid_n;
  logic [SCORE_W-1:0]       score;
  logic [SCORE_W:0]         score_sum;
  logic [SCORE_W-1:0]       score_n;
  logic [1:0]               dir;
  logic [1:0]               line_idx;
  logic                     changed;
  logic [1:0]               spawn_cnt;
  logic [3:0]               spawn_pos;
  logic [3:0]               probe;
  logic [3:0]               probe_cell;
  cell_t                    spawn_tile;
  logic                     ready, busy, done, chg_o, win, lose;
  line_t                    gather, merged;
  logic                     line_chg;
  logic [16:0]              delta;
  logic                     probe_empty, last_line, changed_all, to_done;
  logic                     win_now, stuck_now;

  function automatic logic [3:0] cell_pos(input logic [1:0] d, input logic [1:0] l,
                                          input logic [1:0] k);
    logic [3:0] r;
    case (d)
      DIR_LEFT:  r = idx(k, l);
      DIR_RIGHT: r = idx(~k, l);
      DIR_UP:    r = idx(l, k);
      default:   r = idx(l, ~k);
    endcase
    return r;
  endfunction

  function automatic logic board_stuck(input logic [15:0][CELL_W-1:0] g);
    logic s;
    s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (g[i] == '0) s = 1'b0;
      if ((i % 4) != 3 && g[i] == g[i+1]) s = 1'b0;
      if (i < 12 && g[i] == g[i+4]) s = 1'b0;
    end
    return s;
  endfunction

  function automatic logic board_won(input logic [15:0][CELL_W-1:0] g);
    logic w;
    w = 1'b0;
    for (int i = 0; i < 16; i++) if (g[i] >= CELL_W'(WIN_EXP)) w = 1'b1;
    return w;
  endfunction

  always_comb begin
    gather = '0;
    for (int k = 0; k < 4; k++) gather[k] = grid[cell_pos(dir, line_idx, 2'(k))];
  end

  line_merge u_merge (
    .line_in     (gather),
    .line_out    (merged),
    .changed     (line_chg),
    .score_delta (delta)
  );

  assign probe_cell  = spawn_pos + probe;
  assign probe_empty = (grid[probe_cell] == '0);
  assign last_line   = (line_idx == 2'd3);
  assign changed_all = changed | ((state == MERGE) & line_chg);
  assign score_sum   = {1'b0, score} + {{(SCORE_W-16){1'b0}}, delta};
  assign score_n     = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // Board as it will look after this edge; the flag checks see the final board
  always_comb begin
    grid_n = grid;
    case (state)
      MERGE: for (int k = 0; k < 4; k++) grid_n[cell_pos(dir, line_idx, 2'(k))] = merged[k];
      SPAWN: if (probe_empty) grid_n[probe_cell] = spawn_tile;
      default: grid_n = grid;
    endcase
  end

  assign win_now   = board_won(grid_n);
  assign stuck_now = board_stuck(grid_n);
  assign to_done   = ((state == MERGE) & last_line & ~changed_all) |
                     ((state == SPAWN) & ((probe_empty & (spawn_cnt == 2'd1)) |
                                          (~probe_empty & (probe == 4'hF))));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      grid       <= '0;
      score      <= '0;
      dir        <= '0;
      line_idx   <= '0;
      changed    <= 1'b0;
      spawn_cnt  <= '0;
      spawn_pos  <= '0;
      probe      <= '0;
      spawn_tile <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      chg_o      <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iNew_game) begin
            grid       <= '0;
            score      <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
            changed    <= 1'b1;
            spawn_cnt  <= 2'd2;
            spawn_pos  <= lfsr[3:0];
            spawn_tile <= new_tile(lfsr);
            probe      <= '0;
            ready      <= 1'b0;
            busy       <= 1'b1;
            state      <= SPAWN;
          end else if (bus.iMove_valid) begin
            dir      <= bus.iMove_dir;
            changed  <= 1'b0;
            line_idx <= '0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            state    <= MERGE;
          end
        end
        MERGE: begin
          grid     <= grid_n;
          score    <= score_n;
          line_idx <= line_idx + 2'd1;
          changed  <= changed_all;
          if (last_line) begin
            spawn_cnt  <= 2'd1;
            spawn_pos  <= lfsr[3:0];
            spawn_tile <= new_tile(lfsr);
            probe      <= '0;
            state      <= SPAWN;
          end
        end
        SPAWN: begin
          grid <= grid_n;
          if (probe_empty) begin
            spawn_cnt  <= spawn_cnt - 2'd1;
            spawn_pos  <= lfsr[3:0];
            spawn_tile <= new_tile(lfsr);
            probe      <= '0;
          end else begin
            probe <= probe + 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (to_done) begin
        state <= DONE;
        done  <= 1'b1;
        chg_o <= changed_all;
        win   <= win | win_now;
        lose  <= lose | stuck_now;
      end
    end
  end

  assign bus.oMove_ready = ready;
  assign bus.oGrid       = grid;
  assign bus.oScore      = score;
  assign bus.oBusy       = busy;
  assign bus.oDone       = done;
  assign bus.oChanged    = chg_o;
  assign bus.oWin        = win;
  assign bus.oLose       = lose;

endmodule
